// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial transmit path.
// PAR is only reached when SERIAL_WORD_TX_PARITY_EN is defined.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLR,
      SHIFT,
      PAR
   } state_t;

   localparam int SER_W_DEFAULT = 8;
   localparam int CLR_CYCLES    = 1;

endpackage

// File: rtl/serial_word_tx.sv
// Parallel-in, LSB-first serial-out word transmitter with frame-clear strobe.
// Define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit per frame.
module serial_word_tx
   import serial_pkg::*;
#(
   parameter int W = SER_W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_valid,
   input  logic [W-1:0] load_data,
   output logic         load_ready,
   input  logic         ser_hold,
   output logic         ser_clr,
   output logic         ser_bit,
   output logic         ser_valid,
   output logic         done
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t         r_state;
   logic [W-1:0]   r_sreg;
   logic [CW-1:0]  r_cnt;
   logic           r_ready;
   logic           r_clr;
   logic           r_bit;
   logic           r_valid;
   logic           r_done;

   state_t         w_state;
   logic [W-1:0]   w_sreg;
   logic [CW-1:0]  w_cnt;
   logic           w_clr;
   logic           w_bit;
   logic           w_valid;
   logic           w_done;

`ifdef SERIAL_WORD_TX_PARITY_EN
   logic           r_par;
`endif

   // Outputs are registered, so next-cycle output values are built here
   // alongside next state; a held cycle shows as a bubble one cycle later.
   always_comb begin
      w_state = r_state;
      w_sreg  = r_sreg;
      w_cnt   = r_cnt;
      w_clr   = 1'b0;
      w_bit   = r_bit;
      w_valid = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_bit = 1'b0;
            if (load_valid) begin
               w_state = CLR;
               w_sreg  = load_data;
               w_clr   = 1'b1;
            end
         end
         CLR: begin
            w_state = SHIFT;
            w_cnt   = '0;
            w_valid = 1'b1;
            w_bit   = r_sreg[0];
            w_sreg  = r_sreg >> 1;
         end
         SHIFT: begin
            if (r_valid && (r_cnt == LAST)) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
               w_state = PAR;
               if (!ser_hold) begin
                  w_valid = 1'b1;
                  w_bit   = r_par;
               end
`else
               w_state = IDLE;
               w_done  = 1'b1;
               w_bit   = 1'b0;
`endif
            end else if (!ser_hold) begin
               w_valid = 1'b1;
               w_bit   = r_sreg[0];
               w_sreg  = r_sreg >> 1;
               w_cnt   = r_cnt + CW'(1);
            end
         end
`ifdef SERIAL_WORD_TX_PARITY_EN
         PAR: begin
            if (r_valid) begin
               w_state = IDLE;
               w_done  = 1'b1;
               w_bit   = 1'b0;
            end else if (!ser_hold) begin
               w_valid = 1'b1;
               w_bit   = r_par;
            end
         end
`endif
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_sreg  <= '0;
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_clr   <= 1'b0;
         r_bit   <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_sreg  <= w_sreg;
         r_cnt   <= w_cnt;
         r_ready <= (w_state == IDLE);
         r_clr   <= w_clr;
         r_bit   <= w_bit;
         r_valid <= w_valid;
         r_done  <= w_done;
      end
   end

`ifdef SERIAL_WORD_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_par <= 1'b0;
      end else if ((r_state == IDLE) && load_valid) begin
         r_par <= ^load_data;
      end
   end
`endif

   assign load_ready = r_ready;
   assign ser_clr    = r_clr;
   assign ser_bit    = r_bit;
   assign ser_valid  = r_valid;
   assign done       = r_done;

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: bit stream, strobe timing, hold, reset.
// Honours SERIAL_WORD_TX_PARITY_EN when the DUT is built with it.
module tb_serial_word_tx;

   localparam int W = 8;
`ifdef SERIAL_WORD_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         load_ready;
   logic         ser_hold;
   logic         ser_clr;
   logic         ser_bit;
   logic         ser_valid;
   logic         done;

   serial_word_tx #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .load_valid(load_valid),
      .load_data (load_data),
      .load_ready(load_ready),
      .ser_hold  (ser_hold),
      .ser_clr   (ser_clr),
      .ser_bit   (ser_bit),
      .ser_valid (ser_valid),
      .done      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   bit           exp_bits[$];
   int           exp_clr[$];
   int           exp_done[$];
   logic [W-1:0] exp_neg[$];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, obs, exp, cyc);
      end
   endtask

   // Downstream serial two's-complement model fed by the stream.
   int           mon_idx = 0;
   logic         mon_seen = 1'b0;
   logic [W-1:0] mon_acc = '0;

   always @(negedge clk) begin
      if (ser_clr === 1'b1) begin
         if (exp_clr.size() == 0) chk("clr_unexpected", 1, 0);
         else chk("clr_cycle", cyc, exp_clr.pop_front());
         chk("clr_valid", {31'd0, ser_valid}, 0);
         chk("clr_bit", {31'd0, ser_bit}, 0);
         mon_idx  = 0;
         mon_seen = 1'b0;
         mon_acc  = '0;
      end
      if (ser_valid === 1'b1) begin
         if (exp_bits.size() == 0) chk("bit_unexpected", 1, 0);
         else chk("ser_bit", {31'd0, ser_bit}, {31'd0, exp_bits.pop_front()});
         if (mon_idx < W) begin
            mon_acc[mon_idx] = mon_seen ? ~ser_bit : ser_bit;
            mon_seen = mon_seen | ser_bit;
         end
         mon_idx++;
      end
      if (done === 1'b1) begin
         if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            chk("done_cycle", cyc, exp_done.pop_front());
            chk("frame_len", mon_idx, W + PB);
            chk("neg_result", {24'd0, mon_acc}, {24'd0, exp_neg.pop_front()});
         end
         chk("done_ready", {31'd0, load_ready}, 1);
         chk("done_valid", {31'd0, ser_valid}, 0);
      end
   end

   task automatic send(input logic [W-1:0] d, input int holds, input bit keep);
      int n;
      int t;
      load_data  = d;
      load_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (load_ready === 1'b1) break;
         t++;
         if (t > 100) begin
            chk("send_timeout", 0, 1);
            load_valid = 1'b0;
            return;
         end
      end
      n = cyc + 1;
      exp_clr.push_back(n);
      for (int i = 0; i < W; i++) exp_bits.push_back(d[i]);
      if (PB == 1) exp_bits.push_back(^d);
      exp_done.push_back(n + W + 1 + holds + PB);
      exp_neg.push_back(~d + 1'b1);
      @(posedge clk);
      #1;
      if (!keep) load_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (exp_done.size() != 0) begin
         @(negedge clk);
         t++;
         if (t > 200) begin
            chk("idle_timeout", 0, 1);
            exp_done.delete();
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      ser_hold   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, load_ready}, 1);
      chk("rst_clr", {31'd0, ser_clr}, 0);
      chk("rst_bit", {31'd0, ser_bit}, 0);
      chk("rst_valid", {31'd0, ser_valid}, 0);
      chk("rst_done", {31'd0, done}, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      send(8'h36, 0, 0);
      wait_idle();
      send(8'h07, 0, 0);
      wait_idle();

      send(8'h01, 0, 1);
      send(8'h80, 0, 0);
      wait_idle();

      send(8'hFF, 3, 0);
      repeat (2) @(posedge clk);
      #1 ser_hold = 1'b1;
      repeat (3) @(posedge clk);
      #1 ser_hold = 1'b0;
      wait_idle();

      send(8'h36, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      load_valid = 1'b1;
      load_data  = 8'hAA;
      repeat (3) @(posedge clk);
      #1 load_valid = 1'b0;
      wait_idle();

      send(8'hC3, 0, 0);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      exp_bits.delete();
      exp_done.delete();
      exp_neg.delete();
      @(negedge clk);
      chk("mid_rst_ready", {31'd0, load_ready}, 1);
      chk("mid_rst_clr", {31'd0, ser_clr}, 0);
      chk("mid_rst_bit", {31'd0, ser_bit}, 0);
      chk("mid_rst_valid", {31'd0, ser_valid}, 0);
      chk("mid_rst_done", {31'd0, done}, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;

      send(8'h55, 0, 0);
      wait_idle();
      repeat (3) @(posedge clk);

      chk("bits_left", exp_bits.size(), 0);
      chk("clr_left", exp_clr.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-in, bit-serial-out transmitter that produces the LSB-first serial stream consumed by the team's serial two's-complement unit.
- Accepts a W-bit word via a valid/ready handshake.
- Pulses a frame-clear strobe so the downstream serial unit restarts its state, then shifts the word out LSB first, one bit per clock.
- Sits between a parallel register source and any bit-serial arithmetic consumer.

Parameters:
- W, 8, word width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  source presents a word on load_data.
- load_data  input  W  word to transmit, bit 0 sent first.
- load_ready  output  1  block can accept a word this cycle.
- ser_hold  input  1  stall request from the serial consumer; freezes shifting.
- ser_clr  output  1  frame-start strobe; drives the downstream serial unit's reset.
- ser_bit  output  1  current serial data bit.
- ser_valid  output  1  ser_bit carries a valid data (or parity) bit this cycle.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- All outputs are registered.
- Reset values: load_ready=1, ser_clr=0, ser_bit=0, ser_valid=0, done=0. The FSM enters IDLE, and the shift register and counter are cleared.
- FSM states:
  - IDLE:
    - load_ready=1.
    - On a rising edge with load_valid=1, capture load_data into the shift register and go to CLR.
    - load_ready stays 1 only while in IDLE.
  - CLR:
    - Lasts exactly one cycle: ser_clr=1, ser_valid=0, ser_bit=0.
    - Next state is SHIFT with bit counter=0.
  - SHIFT:
    - ser_valid=1, ser_bit=sreg[0].
    - Each cycle with ser_hold=0: shift the register right by one and increment the counter.
    - After the counter reaches W-1 and that bit has been presented, go to IDLE (or PAR when the optional feature is enabled).
  - PAR (optional feature only): see Optional Feature.
- On returning to IDLE: done=1 for exactly one cycle and ser_valid=0.
  - A new load may be accepted in that same cycle.
  - Back-to-back frames therefore have period W+2 cycles (W+3 with parity).
- Latency: load accepted at edge N.
  - Cycle N+1: ser_clr=1.
  - Cycles N+2..N+1+W: data bits 0..W-1.
  - Cycle N+2+W: done=1.
- ser_hold:
  - Sampled only in SHIFT/PAR.
  - While high, ser_valid=0, ser_bit holds its last value, and the counter and register are frozen.
  - Ignored in IDLE and CLR; the CLR cycle is never stretched.
- load_valid while load_ready=0 is ignored. No queuing; the source must hold the word until ready.
- Reset mid-frame: takes effect on the next edge regardless of state. The frame is dropped, no done pulse is issued, and ser_clr is not asserted by reset itself.
- Bit counter width: $clog2(W). Wrap-around is impossible because exit happens at W-1.
- done and load_ready are both high in the completion cycle. A load accepted then causes ser_clr on the following cycle, with no idle gap.

Optional Feature:
- Macro: SERIAL_WORD_TX_PARITY_EN.
- Defined:
  - After bit W-1, the FSM enters PAR for one cycle with ser_valid=1 and ser_bit = XOR of all W captured bits (even parity).
  - The parity bit is computed at load time.
  - ser_hold freezes PAR the same way it freezes SHIFT.
  - done follows PAR.
- Undefined: no PAR state, no parity logic. Frame = 1 clear cycle + W data cycles.

Decomposition:
- Shared package serial_pkg:
  - state enum (IDLE, CLR, SHIFT, PAR);
  - default width constant SER_W_DEFAULT=8;
  - the CLR_CYCLES=1 constant.
- Single module; no sub-module is natural. Shift register, counter and FSM are tightly coupled.

Test Plan:
- W=8, load 8'h36 at edge N, ser_hold=0 -> ser_clr at N+1; ser_bit 0,1,1,0,1,1,0,0 on N+2..N+9; done at N+10. Feeding the stream into the serial two's-complement unit yields 8'hCA.
- Back-to-back: load_valid held high with 8'h01 then 8'h80 -> second ser_clr in the cycle after the first done; bits 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1; no gap cycles.
- Hold: 8'hFF, ser_hold=1 for 3 cycles after the 2nd bit -> ser_valid low 3 cycles, then 6 more ones; done delayed by exactly 3 cycles (N+13).
- Mid-frame reset after the 4th bit -> next cycle all outputs 0, load_ready=1, no done. A fresh load of 8'h55 then transmits cleanly.
- Busy ignore: load_valid with 8'hAA asserted during SHIFT -> not captured; the in-flight word completes unchanged.
- With SERIAL_WORD_TX_PARITY_EN: 8'h36 -> parity bit 0 at N+10, done at N+11; 8'h07 -> parity bit 1.
